// File: rtl/alarm_ring_ctrl.sv
// Alarm sequencing controller: detects a fresh clock/alarm match edge and runs
// the ring / snooze / stop sequence that drives the buzzer and status LEDs.
module alarm_ring_ctrl #(
    parameter int unsigned RING_SEC   = 60,
    parameter int unsigned SNOOZE_SEC = 300,
    parameter int unsigned MAX_SNOOZE = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_1hz,
    input  logic [3:0] HT_clk,
    input  logic [3:0] HU_clk,
    input  logic [3:0] MT_clk,
    input  logic [3:0] MU_clk,
    input  logic [3:0] HT_alm,
    input  logic [3:0] HU_alm,
    input  logic [3:0] MT_alm,
    input  logic [3:0] MU_alm,
    input  logic       alarm_on,
    input  logic       adj_active,
    input  logic       bt_snooze,
    input  logic       bt_stop,
    output logic       ring,
    output logic       buzz,
    output logic       snoozing,
    output logic [2:0] snooze_left,
    output logic [3:0] leds
);

    typedef enum logic [1:0] {
        DISARMED = 2'd0,
        ARMED    = 2'd1,
        RINGING  = 2'd2,
        SNOOZE   = 2'd3
    } state_t;

    localparam logic [15:0] RING_LAST   = 16'(RING_SEC - 1);
    localparam logic [15:0] SNOOZE_LAST = 16'(SNOOZE_SEC - 1);
    localparam logic [2:0]  SNOOZE_MAX  = 3'(MAX_SNOOZE);

    state_t      r_state;
    logic        r_match_q;
    logic [15:0] r_sec_cnt;
    logic [2:0]  r_snz_cnt;
    logic        r_phase;

    logic        r_ring;
    logic        r_buzz;
    logic        r_snoozing;
    logic [2:0]  r_snooze_left;
    logic [3:0]  r_leds;

    state_t      w_state_nxt;
    logic [15:0] w_sec_nxt;
    logic [2:0]  w_snz_nxt;
    logic        w_phase_nxt;
    logic        w_match;
    logic        w_rise;
    logic        w_ring_stop;

    assign w_match = (HT_clk == HT_alm) && (HU_clk == HU_alm) &&
                     (MT_clk == MT_alm) && (MU_clk == MU_alm);

    // Only a fresh match edge outside adjust mode can start an alarm event.
    assign w_rise = w_match && !r_match_q && !adj_active;

    // While ringing, a snooze request with no snoozes left ends the event like stop.
    assign w_ring_stop = bt_stop || (bt_snooze && (r_snz_cnt == SNOOZE_MAX));

    always_comb begin
        // NOTE: every next-state signal gets a hold default first, so no branch infers a latch.
        w_state_nxt = r_state;
        w_sec_nxt   = r_sec_cnt;
        w_snz_nxt   = r_snz_cnt;
        w_phase_nxt = r_phase;

        if (!alarm_on) begin
            w_state_nxt = DISARMED;
            w_sec_nxt   = '0;
            w_snz_nxt   = '0;
            w_phase_nxt = 1'b0;
        end else begin
            case (r_state)
                DISARMED: begin
                    w_state_nxt = ARMED;
                end

                ARMED: begin
                    if (w_rise) begin
                        w_state_nxt = RINGING;
                        w_sec_nxt   = '0;
                        w_snz_nxt   = '0;
                        w_phase_nxt = 1'b1;
                    end
                end

                RINGING: begin
                    if (w_ring_stop) begin
                        w_state_nxt = ARMED;
                        w_sec_nxt   = '0;
                        w_snz_nxt   = '0;
                    end else if (bt_snooze) begin
                        w_state_nxt = SNOOZE;
                        w_sec_nxt   = '0;
                        w_snz_nxt   = r_snz_cnt + 3'd1;
                    end else if (tick_1hz) begin
                        if (r_sec_cnt == RING_LAST) begin
                            w_state_nxt = ARMED;
                            w_sec_nxt   = '0;
                            w_snz_nxt   = '0;
                        end else begin
                            w_sec_nxt   = r_sec_cnt + 16'd1;
                            w_phase_nxt = !r_phase;
                        end
                    end
                end

                SNOOZE: begin
                    // bt_snooze has no effect here; only stop or the snooze timer act.
                    if (bt_stop) begin
                        w_state_nxt = ARMED;
                        w_sec_nxt   = '0;
                        w_snz_nxt   = '0;
                    end else if (tick_1hz) begin
                        if (r_sec_cnt == SNOOZE_LAST) begin
                            w_state_nxt = RINGING;
                            w_sec_nxt   = '0;
                            w_phase_nxt = 1'b1;
                        end else begin
                            w_sec_nxt   = r_sec_cnt + 16'd1;
                        end
                    end
                end

                default: begin
                    w_state_nxt = DISARMED;
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= DISARMED;
            r_match_q     <= 1'b0;
            r_sec_cnt     <= '0;
            r_snz_cnt     <= '0;
            r_phase       <= 1'b0;
            r_ring        <= 1'b0;
            r_buzz        <= 1'b0;
            r_snoozing    <= 1'b0;
            r_snooze_left <= SNOOZE_MAX;
            r_leds        <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_match_q     <= w_match;
            r_sec_cnt     <= w_sec_nxt;
            r_snz_cnt     <= w_snz_nxt;
            r_phase       <= w_phase_nxt;
            // Outputs are registered from the next state so they track the state register exactly.
            r_ring        <= (w_state_nxt == RINGING);
            r_buzz        <= w_phase_nxt && (w_state_nxt == RINGING);
            r_snoozing    <= (w_state_nxt == SNOOZE);
            r_snooze_left <= SNOOZE_MAX - w_snz_nxt;
            r_leds        <= {(w_state_nxt == RINGING), (w_state_nxt == SNOOZE),
                              (w_state_nxt != DISARMED), alarm_on};
        end
    end

    assign ring        = r_ring;
    assign buzz        = r_buzz;
    assign snoozing    = r_snoozing;
    assign snooze_left = r_snooze_left;
    assign leds        = r_leds;

endmodule

// File: tb/tb_alarm_ring_ctrl.sv
// Self-checking bench for alarm_ring_ctrl: directed scenarios plus a random
// phase, all compared against an event-level reference model.
module tb_alarm_ring_ctrl;

    localparam int RING_SEC   = 4;
    localparam int SNOOZE_SEC = 3;
    localparam int MAX_SNOOZE = 2;

    logic       clk;
    logic       reset;
    logic       tick_1hz;
    logic [3:0] HT_clk, HU_clk, MT_clk, MU_clk;
    logic [3:0] HT_alm, HU_alm, MT_alm, MU_alm;
    logic       alarm_on;
    logic       adj_active;
    logic       bt_snooze;
    logic       bt_stop;
    logic       ring;
    logic       buzz;
    logic       snoozing;
    logic [2:0] snooze_left;
    logic [3:0] leds;

    int checks = 0;
    int errors = 0;

    // Reference model: an alarm event is "ringing" or "snoozing" with a
    // countdown of remaining ticks; buzz follows the parity of ticks rung.
    bit m_armed, m_ringing, m_snoozing, m_prev_match, m_led0;
    int m_left, m_elapsed, m_used;

    alarm_ring_ctrl #(
        .RING_SEC  (RING_SEC),
        .SNOOZE_SEC(SNOOZE_SEC),
        .MAX_SNOOZE(MAX_SNOOZE)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .tick_1hz   (tick_1hz),
        .HT_clk     (HT_clk),
        .HU_clk     (HU_clk),
        .MT_clk     (MT_clk),
        .MU_clk     (MU_clk),
        .HT_alm     (HT_alm),
        .HU_alm     (HU_alm),
        .MT_alm     (MT_alm),
        .MU_alm     (MU_alm),
        .alarm_on   (alarm_on),
        .adj_active (adj_active),
        .bt_snooze  (bt_snooze),
        .bt_stop    (bt_stop),
        .ring       (ring),
        .buzz       (buzz),
        .snoozing   (snoozing),
        .snooze_left(snooze_left),
        .leds       (leds)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_clock(input int h, input int m);
        HT_clk = 4'(h / 10);
        HU_clk = 4'(h % 10);
        MT_clk = 4'(m / 10);
        MU_clk = 4'(m % 10);
    endtask

    task automatic set_alarm(input int h, input int m);
        HT_alm = 4'(h / 10);
        HU_alm = 4'(h % 10);
        MT_alm = 4'(m / 10);
        MU_alm = 4'(m % 10);
    endtask

    function automatic void model_update();
        bit match;
        bit rise;
        match = ({HT_clk, HU_clk, MT_clk, MU_clk} == {HT_alm, HU_alm, MT_alm, MU_alm});
        rise  = match && !m_prev_match && !adj_active;
        if (reset) begin
            m_armed = 0; m_ringing = 0; m_snoozing = 0; m_prev_match = 0; m_led0 = 0;
            m_left = 0; m_elapsed = 0; m_used = 0;
            return;
        end
        m_prev_match = match;
        m_led0       = alarm_on;
        if (!alarm_on) begin
            m_armed = 0; m_ringing = 0; m_snoozing = 0; m_used = 0;
        end else if (!m_armed) begin
            m_armed = 1;
        end else if (m_ringing) begin
            if (bt_stop || (bt_snooze && m_used == MAX_SNOOZE)) begin
                m_ringing = 0; m_used = 0;
            end else if (bt_snooze) begin
                m_ringing = 0; m_snoozing = 1; m_used++; m_left = SNOOZE_SEC;
            end else if (tick_1hz) begin
                m_elapsed++;
                m_left--;
                if (m_left == 0) begin
                    m_ringing = 0; m_used = 0;
                end
            end
        end else if (m_snoozing) begin
            if (bt_stop) begin
                m_snoozing = 0; m_used = 0;
            end else if (tick_1hz) begin
                m_left--;
                if (m_left == 0) begin
                    m_snoozing = 0; m_ringing = 1; m_left = RING_SEC; m_elapsed = 0;
                end
            end
        end else if (rise) begin
            m_ringing = 1; m_left = RING_SEC; m_elapsed = 0; m_used = 0;
        end
    endfunction

    // One clock: model advances on the edge, outputs compared 1 ns later.
    task automatic step(input string tag);
        @(posedge clk);
        model_update();
        #1;
        check({tag, ".ring"},  {3'b0, ring},     {3'b0, m_ringing});
        check({tag, ".buzz"},  {3'b0, buzz},     {3'b0, m_ringing && (m_elapsed % 2 == 0)});
        check({tag, ".snz"},   {3'b0, snoozing}, {3'b0, m_snoozing});
        check({tag, ".left"},  {1'b0, snooze_left}, 4'(MAX_SNOOZE - m_used));
        check({tag, ".leds"},  leds, {m_ringing, m_snoozing, m_armed, m_led0});
    endtask

    task automatic do_tick(input string tag);
        tick_1hz = 1'b1;
        step(tag);
        tick_1hz = 1'b0;
        step(tag);
    endtask

    task automatic press_snooze(input string tag);
        bt_snooze = 1'b1;
        step(tag);
        bt_snooze = 1'b0;
    endtask

    task automatic press_stop(input string tag);
        bt_stop = 1'b1;
        step(tag);
        bt_stop = 1'b0;
    endtask

    task automatic retrigger(input int h, input int m, input string tag);
        set_clock(h, m + 1);
        step(tag);
        set_clock(h, m);
        step(tag);
    endtask

    initial begin
        int ah;
        int am;
        reset = 1'b1; tick_1hz = 1'b0; alarm_on = 1'b0; adj_active = 1'b0;
        bt_snooze = 1'b0; bt_stop = 1'b0;
        set_clock(7, 29);
        set_alarm(7, 30);

        // Reset values
        step("rst");
        check("rst_left", {1'b0, snooze_left}, 4'd2);
        check("rst_leds", leds, 4'b0000);

        // 1: ring on match edge, buzz 1,0,1,0, auto-stop after 4 ticks
        reset = 1'b0; alarm_on = 1'b1;
        step("t1_arm");
        check("t1_arm_leds", leds, 4'b0011);
        set_clock(7, 30);
        step("t1_match");
        check("t1_ring", {3'b0, ring}, 4'd1);
        check("t1_buzz0", {3'b0, buzz}, 4'd1);
        do_tick("t1_tk1");
        check("t1_buzz1", {3'b0, buzz}, 4'd0);
        do_tick("t1_tk2");
        check("t1_buzz2", {3'b0, buzz}, 4'd1);
        do_tick("t1_tk3");
        check("t1_buzz3", {3'b0, buzz}, 4'd0);
        tick_1hz = 1'b1;
        step("t1_tk4");
        tick_1hz = 1'b0;
        check("t1_end_ring", {3'b0, ring}, 4'd0);
        check("t1_end_leds", leds, 4'b0011);

        // 2: snooze twice, third snooze acts as stop
        retrigger(7, 30, "t2_trig");
        check("t2_ring", {3'b0, ring}, 4'd1);
        press_snooze("t2_snz1");
        check("t2_snz1", {3'b0, snoozing}, 4'd1);
        check("t2_left1", {1'b0, snooze_left}, 4'd1);
        repeat (3) do_tick("t2_wait1");
        check("t2_ring_again", {3'b0, ring}, 4'd1);
        press_snooze("t2_snz2");
        check("t2_left0", {1'b0, snooze_left}, 4'd0);
        repeat (3) do_tick("t2_wait2");
        check("t2_ring_third", {3'b0, ring}, 4'd1);
        press_snooze("t2_snz3");
        check("t2_stop_ring", {3'b0, ring}, 4'd0);
        check("t2_stop_left", {1'b0, snooze_left}, 4'd2);
        check("t2_stop_leds", leds, 4'b0011);

        // 3: equality created during adjust does not trigger
        set_clock(6, 0);
        step("t3_clk");
        adj_active = 1'b1;
        set_alarm(6, 0);
        step("t3_adj");
        step("t3_adj");
        adj_active = 1'b0;
        repeat (6) do_tick("t3_hold");
        check("t3_no_ring", {3'b0, ring}, 4'd0);
        retrigger(6, 0, "t3_trig");
        check("t3_ring", {3'b0, ring}, 4'd1);

        // 4: stop+snooze together -> ARMED; snooze on final tick -> SNOOZE
        bt_stop = 1'b1; bt_snooze = 1'b1;
        step("t4_both");
        bt_stop = 1'b0; bt_snooze = 1'b0;
        check("t4_both_snz", {3'b0, snoozing}, 4'd0);
        check("t4_both_leds", leds, 4'b0011);
        step("t4_idle");
        check("t4_idle_snz", {3'b0, snoozing}, 4'd0);
        retrigger(6, 0, "t4_trig");
        repeat (3) do_tick("t4_tk");
        tick_1hz = 1'b1; bt_snooze = 1'b1;
        step("t4_last");
        tick_1hz = 1'b0; bt_snooze = 1'b0;
        check("t4_last_snz", {3'b0, snoozing}, 4'd1);
        check("t4_last_ring", {3'b0, ring}, 4'd0);

        // 5: alarm_on drop while snoozing; re-enable with match held
        alarm_on = 1'b0;
        step("t5_off");
        check("t5_off_leds", leds, 4'b0000);
        check("t5_off_left", {1'b0, snooze_left}, 4'd2);
        alarm_on = 1'b1;
        step("t5_on");
        repeat (4) do_tick("t5_hold");
        check("t5_no_ring", {3'b0, ring}, 4'd0);
        check("t5_leds", leds, 4'b0011);

        // 6: reset mid-ring, no ring until a fresh match edge
        retrigger(6, 0, "t6_trig");
        repeat (2) do_tick("t6_tk");
        check("t6_ringing", {3'b0, ring}, 4'd1);
        reset = 1'b1;
        step("t6_rst");
        reset = 1'b0;
        check("t6_rst_ring", {3'b0, ring}, 4'd0);
        check("t6_rst_buzz", {3'b0, buzz}, 4'd0);
        check("t6_rst_left", {1'b0, snooze_left}, 4'd2);
        check("t6_rst_leds", leds, 4'b0000);
        repeat (4) do_tick("t6_hold");
        check("t6_no_ring", {3'b0, ring}, 4'd0);
        retrigger(6, 0, "t6_trig2");
        check("t6_ring2", {3'b0, ring}, 4'd1);
        press_stop("t6_stop");
        check("t6_stop_ring", {3'b0, ring}, 4'd0);

        // Random phase against the model
        ah = 6; am = 0;
        for (int i = 0; i < 4000; i++) begin
            reset = ($urandom_range(0, 499) == 0);
            if (!alarm_on) alarm_on = ($urandom_range(0, 9) == 0);
            else           alarm_on = ($urandom_range(0, 249) != 0);
            if ($urandom_range(0, 79) == 0) adj_active = ~adj_active;
            tick_1hz  = ($urandom_range(0, 3) == 0);
            bt_stop   = ($urandom_range(0, 39) == 0);
            bt_snooze = !tick_1hz && ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 299) == 0) begin
                ah = int'($urandom_range(0, 23));
                am = int'($urandom_range(0, 59));
                set_alarm(ah, am);
            end
            if ($urandom_range(0, 15) == 0) begin
                if ($urandom_range(0, 1) == 0) set_clock(ah, am);
                else                           set_clock(ah, (am + 1) % 60);
            end
            step("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
